// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl: HUB75 row scanner that fetches upper/lower pixels, shifts PWM bit-planes and lights each row
// between blanking guards.
module hub75_scan_ctrl #(
  parameter int COLS       = 64,
  parameter int ROW_BITS   = 4,
  parameter int PWM_BITS   = 7,
  parameter int COLOR_BITS = 8,
  parameter int CLK_DIV    = 2,
  parameter int OE_GAP     = 4,
  parameter int ON_CYCLES  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             display_ena,
  output logic [ROW_BITS+$clog2(COLS)-1:0] pix_addr,
  input  logic [3*COLOR_BITS-1:0]          pix_rgb1,
  input  logic [3*COLOR_BITS-1:0]          pix_rgb2,
  output logic [2:0]                       display_rgb1,
  output logic [2:0]                       display_rgb2,
  output logic [ROW_BITS-1:0]              d_addr,
  output logic                             d_clk,
  output logic                             d_lat,
  output logic                             d_oe,
  output logic                             frame_done,
  output logic                             busy
);
  localparam int CB = $clog2(COLS);
  localparam int T1 = CLK_DIV > OE_GAP ? CLK_DIV : OE_GAP;
  localparam int TMAX = T1 > ON_CYCLES ? T1 : ON_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [PWM_BITS-1:0] PMAX = PWM_BITS'(2**PWM_BITS - 2);
  localparam logic [CB-1:0] CMAX = CB'(COLS - 1);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, BLANK_PRE, LATCH, BLANK_POST, SHOW} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d, dur;
  logic [CB-1:0] col_q, col_d;
  logic [PWM_BITS-1:0] plane_q, plane_d;
  logic [ROW_BITS-1:0] row_q, row_d, d_addr_q, d_addr_d;
  logic [ROW_BITS+CB-1:0] pix_addr_q, pix_addr_d;
  logic [2:0] rgb1_q, rgb1_d, rgb2_q, rgb2_d, cmp1, cmp2;
  logic d_clk_q, d_clk_d, d_lat_q, d_lat_d, d_oe_q, d_oe_d, fd_q, fd_d, busy_q, busy_d, last;
  logic unused_bits;
  assign unused_bits = ^{pix_rgb1, pix_rgb2};
  assign dur = state_q inside {LOAD, SHIFT, LATCH} ? TW'(CLK_DIV) :
               state_q inside {BLANK_PRE, BLANK_POST} ? TW'(OE_GAP) :
               state_q == SHOW ? TW'(ON_CYCLES) : TW'(1);
  assign last = cnt_q == dur - TW'(1);
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cmp1[i] = pix_rgb1[i*COLOR_BITS+COLOR_BITS-1 -: PWM_BITS] > plane_q;
      cmp2[i] = pix_rgb2[i*COLOR_BITS+COLOR_BITS-1 -: PWM_BITS] > plane_q;
    end
  end
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    plane_d = plane_q;
    row_d = row_q;
    fd_d = 1'b0;
    cnt_d = last ? '0 : cnt_q + TW'(1);
    if (last)
      case (state_q)
        IDLE: if (display_ena) begin
          state_d = FETCH;
          col_d = '0;
          plane_d = '0;
          row_d = '0;
        end
        FETCH: state_d = LOAD;
        LOAD: state_d = SHIFT;
        SHIFT: begin
          state_d = col_q == CMAX ? BLANK_PRE : FETCH;
          col_d = col_q == CMAX ? col_q : col_q + CB'(1);
        end
        BLANK_PRE: state_d = LATCH;
        LATCH: state_d = BLANK_POST;
        BLANK_POST: state_d = SHOW;
        SHOW: begin
          col_d = '0;
          plane_d = plane_q == PMAX ? '0 : plane_q + PWM_BITS'(1);
          row_d = plane_q == PMAX ? row_q + ROW_BITS'(1) : row_q;
          fd_d = plane_q == PMAX && &row_q;
          state_d = fd_d && !display_ena ? IDLE : FETCH;
        end
      endcase
    pix_addr_d = state_d == FETCH ? {row_d, col_d} : pix_addr_q;
    // store data arrives one clock after the address, so sample it at the end of the first LOAD clock
    rgb1_d = state_q == LOAD && cnt_q == '0 ? cmp1 : rgb1_q;
    rgb2_d = state_q == LOAD && cnt_q == '0 ? cmp2 : rgb2_q;
    d_addr_d = state_d == LATCH && state_q == BLANK_PRE ? row_q : d_addr_q;
    d_clk_d = state_d == SHIFT;
    d_lat_d = state_d == LATCH;
    d_oe_d = state_d != SHOW;
    busy_d = state_q != IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      col_q <= '0;
      plane_q <= '0;
      row_q <= '0;
      pix_addr_q <= '0;
      rgb1_q <= '0;
      rgb2_q <= '0;
      d_addr_q <= '0;
      d_clk_q <= 1'b0;
      d_lat_q <= 1'b0;
      d_oe_q <= 1'b1;
      fd_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      col_q <= col_d;
      plane_q <= plane_d;
      row_q <= row_d;
      pix_addr_q <= pix_addr_d;
      rgb1_q <= rgb1_d;
      rgb2_q <= rgb2_d;
      d_addr_q <= d_addr_d;
      d_clk_q <= d_clk_d;
      d_lat_q <= d_lat_d;
      d_oe_q <= d_oe_d;
      fd_q <= fd_d;
      busy_q <= busy_d;
    end
  assign pix_addr = pix_addr_q;
  assign display_rgb1 = rgb1_q;
  assign display_rgb2 = rgb2_q;
  assign d_addr = d_addr_q;
  assign d_clk = d_clk_q;
  assign d_lat = d_lat_q;
  assign d_oe = d_oe_q;
  assign frame_done = fd_q;
  assign busy = busy_q;
endmodule
